// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W SRAM array model: clear FSM states,
// write-mask lane expansion and geometry legality checks.
package sram_pkg;

   typedef enum logic [1:0] {
      RESET,
      CLEAR,
      READY
   } clr_state_e;

   // Upper bounds for the mask expansion helper; real geometries are sliced down.
   localparam int MAX_DATA_WIDTH = 512;
   localparam int MAX_MASK_WIDTH = 512;
   localparam int MAX_IDX_W      = 9;

   function automatic bit geom_ok(input int aw, input int dw, input int gran);
      return (aw >= 1) && (dw >= 1) && (dw <= MAX_DATA_WIDTH) &&
             (gran >= 1) && ((dw % gran) == 0) && ((dw / gran) <= MAX_MASK_WIDTH);
   endfunction

   // Bit i of the result copies mask lane i/gran.
   function automatic logic [MAX_DATA_WIDTH-1:0] expand_mask(
      input logic [MAX_MASK_WIDTH-1:0] mask,
      input int                        gran
   );
      logic [MAX_DATA_WIDTH-1:0] bits;
      bits = '0;
      for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
         bits[MAX_IDX_W'(i)] = mask[MAX_IDX_W'(i / gran)];
      end
      return bits;
   endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing the init value,
// then raises init_done_o.
module sram_clear_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clock,
   input  logic                  reset_n,
   output logic                  clr_we_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o,
   output logic                  init_done_o
);

   clr_state_e            state_q, state_d;
   // One extra bit so the terminal count DEPTH is seen without wrapping to 0.
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_o = 1'b0;
      case (state_q)
         RESET: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
         CLEAR: begin
            clr_we_o = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_d[ADDR_WIDTH]) state_d = READY;
         end
         READY: ;
         default: state_d = RESET;
      endcase
   end

   assign clr_addr_o  = cnt_q[ADDR_WIDTH-1:0];
   assign init_done_o = (state_q == READY);

endmodule

// File: rtl/sram_array_1r1w_ext.sv
// 1R1W SRAM array model with lane write masks, optional output register and
// self-clear after reset. Define SRAM_WR_BYPASS_EN to forward same-cycle writes.
module sram_array_1r1w_ext
   import sram_pkg::*;
#(
   parameter int                          ADDR_WIDTH = 11,
   parameter int                          DATA_WIDTH = 40,
   parameter int                          MASK_GRAN  = 4,
   parameter int                          OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0]       INIT_VALUE = '0
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           R0_en,
   input  logic [ADDR_WIDTH-1:0]          R0_addr,
   output logic [DATA_WIDTH-1:0]          R0_data,
   output logic                           R0_valid,
   input  logic                           W0_en,
   input  logic [ADDR_WIDTH-1:0]          W0_addr,
   input  logic [DATA_WIDTH/MASK_GRAN-1:0] W0_mask,
   input  logic [DATA_WIDTH-1:0]          W0_data,
   output logic                           init_done
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (!geom_ok(ADDR_WIDTH, DATA_WIDTH, MASK_GRAN)) begin : g_bad_geom
      $error("sram_array_1r1w_ext: illegal ADDR_WIDTH/DATA_WIDTH/MASK_GRAN");
   end

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  rd_acc, wr_acc;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] rd_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   sram_clear_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_ctrl (
      .clock       (clock),
      .reset_n     (reset_n),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr),
      .init_done_o (init_done)
   );

   assign rd_acc = R0_en & init_done;
   assign wr_acc = W0_en & init_done;
   assign wmask  = DATA_WIDTH'(expand_mask(MAX_MASK_WIDTH'(W0_mask), MASK_GRAN));

   // Storage has no reset: contents are defined only by the clear sequence.
   always_ff @(posedge clock) begin
      if (clr_we) begin
         mem[clr_addr] <= INIT_VALUE;
      end else if (wr_acc) begin
         mem[W0_addr] <= (mem[W0_addr] & ~wmask) | (W0_data & wmask);
      end
   end

   always_comb begin
      rd_d = mem[R0_addr];
`ifdef SRAM_WR_BYPASS_EN
      if (wr_acc && (W0_addr == R0_addr)) begin
         rd_d = (rd_d & ~wmask) | (W0_data & wmask);
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= rd_acc;
         if (rd_acc) rd_data_q <= rd_d;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic                  out_vld_q;
      logic [DATA_WIDTH-1:0] out_data_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
         end else begin
            out_vld_q <= rd_vld_q;
            if (rd_vld_q) out_data_q <= rd_data_q;
         end
      end

      assign R0_valid = out_vld_q;
      assign R0_data  = out_data_q;
   end else begin : g_no_out_reg
      assign R0_valid = rd_vld_q;
      assign R0_data  = rd_data_q;
   end

endmodule

// File: tb/tb_sram_array_1r1w_ext.sv
// Bench for sram_array_1r1w_ext (ADDR_WIDTH=4, OUT_REG=1) against an array model.
module tb_sram_array_1r1w_ext;

   localparam int          AW    = 4;
   localparam int          DW    = 40;
   localparam int          MW    = 10;
   localparam int          DEPTH = 16;
   localparam int          LAT   = 2;
   localparam logic [DW-1:0] INIT = 40'hA5_C3C3_5A69;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          R0_en = 1'b0;
   logic [AW-1:0] R0_addr = '0;
   logic [DW-1:0] R0_data;
   logic          R0_valid;
   logic          W0_en = 1'b0;
   logic [AW-1:0] W0_addr = '0;
   logic [MW-1:0] W0_mask = '0;
   logic [DW-1:0] W0_data = '0;
   logic          init_done;

   sram_array_1r1w_ext #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MASK_GRAN  (4),
      .OUT_REG    (1),
      .INIT_VALUE (INIT)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .R0_en     (R0_en),
      .R0_addr   (R0_addr),
      .R0_data   (R0_data),
      .R0_valid  (R0_valid),
      .W0_en     (W0_en),
      .W0_addr   (W0_addr),
      .W0_mask   (W0_mask),
      .W0_data   (W0_data),
      .init_done (init_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } pend_t;

   int            npass = 0;
   int            ntotal = 0;
   int            cyc = 0;
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] last_d = '0;
   pend_t         pend [$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < MW; i++) if (m[i]) r[i*4 +: 4] = nw[i*4 +: 4];
      return r;
   endfunction

   // Apply the current inputs to the model, clock once, then check all outputs.
   task automatic tick();
      logic [DW-1:0] v;
      logic          ev;
      if (cyc >= DEPTH + 1) begin
         if (R0_en) begin
            v = ref_mem[R0_addr];
`ifdef SRAM_WR_BYPASS_EN
            if (W0_en && W0_addr == R0_addr) v = merge(v, W0_data, W0_mask);
`endif
            pend.push_back('{cyc + LAT, v});
         end
         if (W0_en) ref_mem[W0_addr] = merge(ref_mem[W0_addr], W0_data, W0_mask);
      end
      @(posedge clock);
      #1;
      cyc++;
      ev = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         ev     = 1'b1;
         last_d = pend[0].d;
         void'(pend.pop_front());
      end
      chk("init_done", DW'(init_done), DW'(cyc >= DEPTH + 1));
      chk("R0_valid", DW'(R0_valid), DW'(ev));
      chk("R0_data", R0_data, last_d);
   endtask

   task automatic drive(input logic ren, input logic [AW-1:0] ra, input logic wen,
                        input logic [AW-1:0] wa, input logic [MW-1:0] wm, input logic [DW-1:0] wd);
      R0_en = ren; R0_addr = ra; W0_en = wen; W0_addr = wa; W0_mask = wm; W0_data = wd;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0);
   endtask

   task automatic apply_reset();
      R0_en = 1'b0; W0_en = 1'b0;
      reset_n = 1'b0;
      #2;
      chk("rst_R0_data", R0_data, '0);
      chk("rst_R0_valid", DW'(R0_valid), '0);
      chk("rst_init_done", DW'(init_done), '0);
      pend.delete();
      last_d = '0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) drive(1'b1, AW'(a), 1'b0, '0, '0, '0);
      idle(LAT);
   endtask

   initial begin
      logic [63:0] rnd;
      #1;
      apply_reset();

      // Requests in clear cycle 2 must be dropped.
      idle(2);
      drive(1'b1, 4'd3, 1'b1, 4'd3, 10'h3FF, 40'hFF);
      idle(DEPTH + 1 - cyc);
      read_all();
      drive(1'b1, 4'd3, 1'b0, '0, '0, '0);
      idle(1);
      chk("clear_drops_write", R0_data, INIT);

      // Masked writes.
      drive(1'b0, '0, 1'b1, 4'd5, 10'h3FF, 40'h00000000FF);
      drive(1'b0, '0, 1'b1, 4'd5, 10'h003, 40'hABCDEF1234);
      drive(1'b1, 4'd5, 1'b0, '0, '0, '0);
      idle(1);
      chk("masked_write", R0_data, 40'h0000000034);
      drive(1'b0, '0, 1'b1, 4'd6, 10'h000, 40'hFFFFFFFFFF);
      drive(1'b1, 4'd6, 1'b0, '0, '0, '0);
      idle(1);
      chk("mask_zero_noop", R0_data, INIT);

      // Pipelined reads with the output register; data holds afterwards.
      drive(1'b0, '0, 1'b1, 4'd1, 10'h3FF, 40'h0101010101);
      drive(1'b0, '0, 1'b1, 4'd2, 10'h3FF, 40'h0202020202);
      drive(1'b0, '0, 1'b1, 4'd3, 10'h3FF, 40'h0303030303);
      drive(1'b1, 4'd1, 1'b0, '0, '0, '0);
      drive(1'b1, 4'd2, 1'b0, '0, '0, '0);
      drive(1'b1, 4'd3, 1'b0, '0, '0, '0);
      idle(3);
      chk("latency_hold", R0_data, 40'h0303030303);

      // Same-address collision.
      drive(1'b0, '0, 1'b1, 4'd7, 10'h3FF, 40'h1111111111);
      drive(1'b1, 4'd7, 1'b1, 4'd7, 10'h001, 40'h2222222222);
      idle(1);
`ifdef SRAM_WR_BYPASS_EN
      chk("collision", R0_data, 40'h1111111112);
`else
      chk("collision", R0_data, 40'h1111111111);
`endif
      idle(1);
      drive(1'b1, 4'd7, 1'b0, '0, '0, '0);
      idle(1);
      chk("collision_after", R0_data, 40'h1111111112);

      // Randomized traffic with a narrow address space to force collisions.
      for (int i = 0; i < 300; i++) begin
         rnd = {$urandom(), $urandom()};
         drive(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               MW'($urandom_range(0, 1023)), rnd[DW-1:0]);
      end
      idle(LAT);

      // Reset from READY, then abort a clear at cycle 8.
      apply_reset();
      idle(8);
      chk("midclear_no_init", DW'(init_done), '0);
      apply_reset();
      idle(DEPTH + 1);
      chk("reinit_done", DW'(init_done), 1);
      read_all();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout npass=%0d ntotal=%0d", npass, ntotal);
      $fatal(1, "timeout");
   end

endmodule
